// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared SIZ/DSACK encodings, FSM states and lane helpers for m68k_bus_master
package m68k_bus_pkg;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] DSK_32   = 2'b00;
    localparam logic [1:0] DSK_16   = 2'b01;
    localparam logic [1:0] DSK_8    = 2'b10;
    localparam logic [1:0] DSK_WAIT = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ASRT, S_WAIT, S_TERM, S_DONE} state_t;

    // Byte lane (0 = D[31:24]) where the first addressed byte appears for a given port width.
    function automatic logic [1:0] lane_sel(input logic [1:0] a, input logic [1:0] dsack);
        return dsack == DSK_32 ? a : dsack == DSK_16 ? {1'b0, a[0]} : 2'b00;
    endfunction

    // Bytes moved by one sub-cycle; a 32-bit port stops at the long boundary.
    function automatic logic [2:0] xfer_bytes(input logic [1:0] a, input logic [1:0] dsack,
                                              input logic [2:0] rem);
        logic [2:0] lim;
        lim = dsack == DSK_32 ? 3'd4 - {1'b0, a} : dsack == DSK_16 ? 3'd2 : 3'd1;
        return lim < rem ? lim : rem;
    endfunction
endpackage

// File: rtl/m68k_bus_master_if.sv
// m68k_bus_master_if: request/done handshake plus 68020 bus signals
//  master modport = initiator view (m68k_bus_master), slave = requester + responder view
interface m68k_bus_master_if;
    logic        req;
    logic [23:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [23:0] A;
    logic [1:0]  SIZ;
    logic        AS20;
    logic        DS20;
    logic        RW20;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic [31:0] D_IN;
    logic [1:0]  DSACK;
    logic        BERR;

    modport master (
        input  req, req_addr, req_we, req_size, req_wdata, D_IN, DSACK, BERR,
        output busy, done, err, rdata, A, SIZ, AS20, DS20, RW20, D_OUT, D_OE
    );
    modport slave (
        output req, req_addr, req_we, req_size, req_wdata, D_IN, DSACK, BERR,
        input  busy, done, err, rdata, A, SIZ, AS20, DS20, RW20, D_OUT, D_OE
    );
endinterface

// File: rtl/m68k_lane_mux.sv
// m68k_lane_mux: write-lane placement and read-byte extraction
//  wdata/rem -> dout : remaining operand bytes placed on the data lanes
//  din/lane/n -> rbytes : n bytes starting at lane, right-justified
module m68k_lane_mux (
    input  logic [31:0] wdata,
    input  logic [2:0]  rem,
    output logic [31:0] dout,
    input  logic [31:0] din,
    input  logic [1:0]  lane,
    input  logic [2:0]  n,
    output logic [31:0] rbytes
);
    // wdata is never shifted: rem selects the still-unsent low bytes and puts the next one on D[31:24].
    always_comb begin
        dout   = rem == 3'd1 ? {4{wdata[7:0]}} :
                 rem == 3'd2 ? {2{wdata[15:0]}} :
                 rem == 3'd3 ? {wdata[23:0], wdata[7:0]} :
                 rem == 3'd4 ? wdata : 32'h0;
        rbytes = (din << {lane, 3'b000}) >> (6'd32 - {n, 3'b000});
    end
endmodule

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: 68020-style bus initiator with dynamic bus sizing and timeout
//  CLKCPU, RESET (async, active high); bus: m68k_bus_master_if.master
//  (req/req_* in, busy/done/err/rdata out, A/SIZ/AS20/DS20/RW20/D_OUT/D_OE out, D_IN/DSACK/BERR in)
module m68k_bus_master
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input logic               CLKCPU,
    input logic               RESET,
    m68k_bus_master_if.master bus
);
    state_t      state, state_nx;
    logic [23:0] addr;
    logic [2:0]  rem, n, n_now, rem_init;
    logic [1:0]  lane;
    logic [31:0] wbuf, acc, rbytes;
    logic [7:0]  cnt;
    logic        we, err_r, bad, ack, berr, tmo;

    assign bad      = bus.req_size == 2'b11 || (bus.req_size == SIZ_WORD && bus.req_addr[0]) ||
                      (bus.req_size == SIZ_LONG && bus.req_addr[1:0] != 2'b00);
    assign rem_init = bus.req_size == SIZ_BYTE ? 3'd1 : bus.req_size == SIZ_WORD ? 3'd2 : 3'd4;
    assign ack      = bus.DSACK != DSK_WAIT;
    assign berr     = !bus.BERR;
    assign tmo      = cnt == 8'(TIMEOUT - 1);
    assign n_now    = xfer_bytes(addr[1:0], bus.DSACK, rem);
    assign lane     = lane_sel(addr[1:0], bus.DSACK);

    m68k_lane_mux u_mux (
        .wdata (wbuf),
        .rem   (rem),
        .dout  (bus.D_OUT),
        .din   (bus.D_IN),
        .lane  (lane),
        .n     (n_now),
        .rbytes(rbytes)
    );

    always_ff @(posedge CLKCPU or posedge RESET)
        if (RESET) state <= S_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = !bus.req ? S_IDLE : bad ? S_DONE : S_ADDR;
            S_ADDR:  state_nx = S_ASRT;
            S_ASRT:  state_nx = S_WAIT;
            S_WAIT:  state_nx = (berr || ack || tmo) ? S_TERM : S_WAIT;
            S_TERM:  state_nx = (rem != n && !err_r) ? S_ADDR : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so RESET negates them without waiting for a clock.
    assign bus.busy  = state != S_IDLE;
    assign bus.done  = state == S_DONE;
    assign bus.err   = state == S_DONE && err_r;
    assign bus.rdata = acc;
    assign bus.A     = addr;
    assign bus.SIZ   = rem[1:0];
    assign bus.AS20  = !(state == S_ASRT || state == S_WAIT);
    assign bus.DS20  = !(state == S_WAIT || (state == S_ASRT && !we));
    assign bus.D_OE  = we && state inside {S_ADDR, S_ASRT, S_WAIT};
    assign bus.RW20  = !(we && state inside {S_ADDR, S_ASRT, S_WAIT, S_TERM});

    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            addr  <= '0;
            rem   <= '0;
            n     <= '0;
            wbuf  <= '0;
            acc   <= '0;
            cnt   <= '0;
            we    <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.req) begin
                addr  <= bus.req_addr;
                we    <= bus.req_we;
                wbuf  <= bus.req_wdata;
                acc   <= '0;
                err_r <= bad;
                rem   <= bad ? 3'd0 : rem_init;
            end
            if (state == S_ASRT) cnt <= '0;
            // BERR outranks DSACK; a timeout only fires when nothing terminated the cycle.
            if (state == S_WAIT) begin
                if (berr || (!ack && tmo)) begin
                    err_r <= 1'b1;
                    n     <= '0;
                end else if (ack) begin
                    n <= n_now;
                    if (!we) acc <= (acc << {n_now, 3'b000}) | rbytes;
                end else cnt <= cnt + 8'd1;
            end
            if (state == S_TERM) begin
                rem  <= rem - n;
                addr <= addr + 24'(n);
            end
        end
    end
endmodule

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: random and directed transfers against a byte-memory responder model
module tb_m68k_bus_master;
    logic CLKCPU = 1'b0;
    logic RESET  = 1'b1;
    m68k_bus_master_if bus ();
    m68k_bus_master #(.TIMEOUT(64)) dut (.CLKCPU(CLKCPU), .RESET(RESET), .bus(bus));
    always #5 CLKCPU = ~CLKCPU;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mem [256];
    int mode = 0;
    logic [1:0] pcode = 2'b00;
    int dmin = 0;
    int dmax = 0;
    int wcnt, dly;
    bit pres;
    logic [27:0] sub_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mn(input int x, input int y);
        return x < y ? x : y;
    endfunction

    // Responder: acts like an 8/16/32-bit port backed by mem; records every terminated sub-cycle.
    task automatic respond();
        int a, sb, nb, j, b;
        a  = int'(bus.A[7:0]);
        sb = bus.SIZ == 2'b00 ? 4 : int'(bus.SIZ);
        nb = pcode == 2'b00 ? mn(4 - a % 4, sb) : pcode == 2'b01 ? mn(2 - a % 2, sb) : 1;
        sub_q.push_back({bus.RW20, bus.D_OE, bus.A, bus.SIZ});
        if (!bus.RW20) begin
            for (int i = 0; i < nb; i++) begin
                j = pcode == 2'b10 ? 0 : pcode == 2'b01 ? (a + i) % 2 : (a + i) % 4;
                mem[(a + i) & 255] = bus.D_OUT[31 - 8 * j -: 8];
            end
        end else if (pcode == 2'b00) begin
            b = a & 252;
            bus.D_IN = {mem[b], mem[b + 1], mem[b + 2], mem[b + 3]};
        end else if (pcode == 2'b01) begin
            b = a & 254;
            bus.D_IN = {mem[b], mem[b + 1], 16'($urandom)};
        end else bus.D_IN = {mem[a], 24'($urandom)};
        bus.DSACK = pcode;
    endtask

    always @(negedge CLKCPU) begin
        if (RESET || bus.AS20) begin
            bus.DSACK = 2'b11;
            bus.BERR  = 1'b1;
            bus.D_IN  = $urandom;
            pres = 0;
            wcnt = 0;
            dly  = $urandom_range(dmin, dmax);
        end else if (!bus.DS20 && !pres) begin
            if (mode == 1) bus.BERR = 1'b0;
            else if (mode == 0) begin
                if (wcnt < dly) wcnt++;
                else begin
                    respond();
                    pres = 1;
                end
            end
        end
    end

    // md: 0 = normal termination, 1 = BERR, 2 = DSACK never arrives
    task automatic txn(input logic [23:0] ad, input logic [1:0] sz, input bit we, input logic [31:0] wd,
                       input logic [1:0] pc, input int md, input int d0, input int d1);
        int nbytes, asl, r, a, nx;
        bit bad, seen;
        logic [31:0] exp_rd;
        logic [27:0] exp_q[$];
        mode = md;
        pcode = pc;
        dmin = d0;
        dmax = d1;
        sub_q.delete();
        nbytes = sz == 2'b01 ? 1 : sz == 2'b10 ? 2 : 4;
        bad = sz == 2'b11 || (sz == 2'b10 && ad[0]) || (sz == 2'b00 && ad[1:0] != 2'b00);
        exp_rd = 0;
        for (int i = 0; i < nbytes; i++) exp_rd = {exp_rd[23:0], mem[(int'(ad[7:0]) + i) & 255]};
        a = int'(ad);
        r = nbytes;
        if (!bad && md == 0)
            while (r > 0) begin
                exp_q.push_back({~we, we, 24'(a), 2'(r)});
                nx = pc == 2'b00 ? mn(4 - a % 4, r) : pc == 2'b01 ? mn(2 - a % 2, r) : 1;
                a += nx;
                r -= nx;
            end
        @(negedge CLKCPU);
        bus.req = 1'b1;
        bus.req_addr = ad;
        bus.req_size = sz;
        bus.req_we = we;
        bus.req_wdata = wd;
        @(negedge CLKCPU);
        bus.req = 1'b0;
        seen = 0;
        asl = 0;
        for (int c = 0; c < 300; c++) begin
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (!bus.AS20) asl++;
            if (!bad && c == 2) begin
                bus.req = 1'b1;
                bus.req_addr = 24'($urandom);
                bus.req_size = 2'($urandom);
                bus.req_we = 1'($urandom);
                bus.req_wdata = $urandom;
            end
            if (c == 3) bus.req = 1'b0;
            @(negedge CLKCPU);
        end
        chk("done_seen", seen, 1);
        if (!seen) begin
            RESET = 1'b1;
            @(negedge CLKCPU);
            RESET = 1'b0;
            return;
        end
        chk("err", bus.err, bad || md != 0);
        if (!bad && md == 0) begin
            chk("nsub", sub_q.size(), exp_q.size());
            for (int i = 0; i < mn(sub_q.size(), exp_q.size()); i++) chk("subcycle", sub_q[i], exp_q[i]);
            if (!we) chk("rdata", bus.rdata, exp_rd);
            else
                for (int i = 0; i < nbytes; i++)
                    chk("wbyte", mem[(int'(ad[7:0]) + i) & 255], wd[8 * (nbytes - 1 - i) +: 8]);
        end
        if (bad) chk("as_never", asl, 0);
        if (md == 2 && !bad) chk("tmo_as_cycles", asl, 65);
        if (md == 1) chk("berr_nsub", sub_q.size(), 0);
        @(negedge CLKCPU);
        chk("done_pulse", bus.done, 0);
        chk("idle_after", bus.busy, 0);
    endtask

    initial begin
        int dn;
        bus.req = 1'b0;
        bus.req_addr = '0;
        bus.req_size = '0;
        bus.req_we = 1'b0;
        bus.req_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        @(negedge CLKCPU);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_A", bus.A, 0);
        chk("rst_SIZ", bus.SIZ, 0);
        chk("rst_strobes", {bus.AS20, bus.DS20, bus.RW20, bus.D_OE}, 4'b1110);
        chk("rst_DOUT", bus.D_OUT, 0);
        @(negedge CLKCPU);
        RESET = 1'b0;

        {mem[0], mem[1], mem[2], mem[3]} = 32'hDEADBEEF;
        txn(24'h000100, 2'b00, 0, 32'h0, 2'b00, 0, 2, 2);
        txn(24'h000200, 2'b00, 1, 32'h11223344, 2'b10, 0, 0, 1);
        {mem[2], mem[3]} = 16'hA5C3;
        txn(24'h000302, 2'b10, 0, 32'h0, 2'b01, 0, 0, 1);
        txn(24'hDA2001, 2'b01, 0, 32'h0, 2'b00, 1, 0, 0);
        txn(24'h000100, 2'b00, 0, 32'h0, 2'b00, 2, 0, 0);
        txn(24'h000001, 2'b10, 0, 32'h0, 2'b00, 0, 0, 0);
        txn(24'h000104, 2'b11, 1, 32'h12345678, 2'b00, 0, 0, 0);

        // RESET in the middle of a write's wait state
        mode = 2;
        pcode = 2'b10;
        @(negedge CLKCPU);
        bus.req = 1'b1;
        bus.req_addr = 24'h000040;
        bus.req_size = 2'b00;
        bus.req_we = 1'b1;
        bus.req_wdata = 32'hCAFEF00D;
        @(negedge CLKCPU);
        bus.req = 1'b0;
        repeat (3) @(negedge CLKCPU);
        chk("mid_as_low", {bus.AS20, bus.DS20, bus.D_OE}, 3'b001);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_strobes", {bus.AS20, bus.DS20, bus.D_OE}, 3'b110);
        chk("mid_rst_busy", bus.busy, 0);
        @(negedge CLKCPU);
        RESET = 1'b0;
        dn = 0;
        repeat (5) begin
            @(negedge CLKCPU);
            dn += int'(bus.done);
        end
        chk("mid_rst_no_done", dn, 0);

        for (int t = 0; t < 160; t++) begin
            logic [23:0] ad;
            logic [1:0] sz, pc;
            int md, k;
            ad = 24'($urandom);
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b00;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b10) ad[0] = 1'b0;
                if (sz == 2'b00) ad[1:0] = 2'b00;
            end
            k = $urandom_range(0, 2);
            pc = k == 0 ? 2'b00 : k == 1 ? 2'b01 : 2'b10;
            k = $urandom_range(0, 19);
            md = k == 0 ? 1 : k == 1 ? 2 : 0;
            txn(ad, sz, 1'($urandom), $urandom, pc, md, 0, 3);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
